// File: rtl/stopwatch_counter_if.sv
// Port bundle between the stopwatch counter and its neighbours: raw buttons in,
// registered count and status out, plus the FSM state for debug.
interface stopwatch_counter_if;
   // There is no valid/ready handshake on this bundle. Buttons are raw asynchronous
   // levels. bcd_out, running, overflow and fsm_state are registered levels that
   // hold until they change, so they can be sampled on any cycle.
   logic        btn_start_stop;
   logic        btn_clear;
   logic [15:0] bcd_out;
   logic        running;
   logic        overflow;
   logic [1:0]  fsm_state;

   modport master (
      output btn_start_stop, btn_clear,
      input  bcd_out, running, overflow, fsm_state
   );

   modport slave (
      input  btn_start_stop, btn_clear,
      output bcd_out, running, overflow, fsm_state
   );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch core: button conditioning, start/pause/clear FSM, prescaler and 4-digit BCD count.
// Optional macro STOPWATCH_SATURATE_EN: hold at 9999 and force PAUSE instead of wrapping.
module stopwatch_counter #(
   parameter int TICK_DIV  = 100000,
   parameter int DB_CYCLES = 50000
) (
   input logic               clk,
   input logic               rst,
   stopwatch_counter_if.slave bus
);

   localparam int PW  = $clog2(TICK_DIV);
   localparam int DBW = $clog2(DB_CYCLES);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   // Index 0 is start/stop and index 1 is clear.
   logic [1:0]     sync1, sync2, db_lvl, db_prev;
   logic [DBW-1:0] db_cnt [2];
   logic [1:0]     press;
   logic           start_p, clear_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         db_lvl  <= '0;
         db_prev <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1   <= {bus.btn_clear, bus.btn_start_stop};
         sync2   <= sync1;
         db_prev <= db_lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               db_lvl[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   assign press   = db_lvl & ~db_prev;
   assign start_p = press[0];
   assign clear_p = press[1];

   function automatic logic [15:0] bcd_incr(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic [1:0]    state, state_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [15:0]   bcd, bcd_nxt;
   logic          ovf, ovf_nxt;
   logic          running;
   logic          tick, at_max;

   assign tick   = (state == S_RUN) && (presc == PRESC_MAX);
   assign at_max = (bcd == 16'h9999);

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      bcd_nxt   = bcd;
      ovf_nxt   = ovf;
      if (clear_p) begin
         state_nxt = S_IDLE;
         presc_nxt = '0;
         bcd_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         if (state == S_RUN) presc_nxt = tick ? '0 : presc + PW'(1);
         if (tick) begin
`ifdef STOPWATCH_SATURATE_EN
            if (at_max) begin
               ovf_nxt   = 1'b1;
               state_nxt = S_PAUSE;
            end else begin
               bcd_nxt = bcd_incr(bcd);
            end
`else
            bcd_nxt = bcd_incr(bcd);
            if (at_max) ovf_nxt = 1'b1;
`endif
         end
         // A press coinciding with a tick still lets the tick land before pausing.
         if (start_p) begin
            case (state)
               S_IDLE:  state_nxt = S_RUN;
               S_RUN:   state_nxt = S_PAUSE;
`ifdef STOPWATCH_SATURATE_EN
               S_PAUSE: if (!ovf) state_nxt = S_RUN;
`else
               S_PAUSE: state_nxt = S_RUN;
`endif
               default: state_nxt = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         presc   <= '0;
         bcd     <= '0;
         ovf     <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         presc   <= presc_nxt;
         bcd     <= bcd_nxt;
         ovf     <= ovf_nxt;
         running <= (state_nxt == S_RUN);
      end
   end

   assign bus.bcd_out   = bcd;
   assign bus.running   = running;
   assign bus.overflow  = ovf;
   assign bus.fsm_state = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4, DB_CYCLES=3; expected outputs
// go through a queue that a negedge monitor drains and compares.
module tb_stopwatch_counter;
   localparam int TICK_DIV  = 4;
   localparam int DB_CYCLES = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stopwatch_counter_if sw_if ();

   stopwatch_counter #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sw_if)
   );

   // ---------------- scoreboard ----------------
   logic [17:0] exp_q[$];
   string       name_q[$];
   int          checks  = 0;
   int          passed  = 0;
   int          nib_bad = 0;

   always @(negedge clk) begin : monitor
      logic [17:0] e;
      logic [17:0] act;
      string       nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {sw_if.bcd_out, sw_if.running, sw_if.overflow};
         checks++;
         if (act === e) passed++;
         else $display("FAIL %s: got bcd=%h running=%b overflow=%b, want bcd=%h running=%b overflow=%b",
                       nm, act[17:2], act[1], act[0], e[17:2], e[1], e[0]);
      end
      if (rst === 1'b0) begin
         for (int d = 0; d < 4; d++) if (sw_if.bcd_out[4*d +: 4] > 4'd9) nib_bad++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic [15:0] b, input logic r, input logic o);
      exp_q.push_back({b, r, o});
      name_q.push_back(nm);
   endtask

   // Raw press held 6 cycles: the FSM edge lands on the 6th posedge, then release.
   task automatic press_start();
      sw_if.btn_start_stop = 1'b1;
      cycles(6);
      sw_if.btn_start_stop = 1'b0;
   endtask

   task automatic press_clear();
      sw_if.btn_clear = 1'b1;
      cycles(6);
      sw_if.btn_clear = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end within the time limit");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      sw_if.btn_start_stop = 1'b0;
      sw_if.btn_clear      = 1'b0;

      // Reset held two cycles while the buttons move.
      cycles(1);
      expect_out("rst_cycle1", 16'h0000, 1'b0, 1'b0);
      sw_if.btn_start_stop = 1'b1;
      sw_if.btn_clear      = 1'b1;
      cycles(1);
      expect_out("rst_cycle2", 16'h0000, 1'b0, 1'b0);
      sw_if.btn_start_stop = 1'b0;
      sw_if.btn_clear      = 1'b0;
      rst = 1'b0;
      cycles(1);
      expect_out("post_rst", 16'h0000, 1'b0, 1'b0);
      cycles(4);
      expect_out("idle_hold", 16'h0000, 1'b0, 1'b0);

      // Two-cycle glitch is the longest pulse that must be rejected.
      sw_if.btn_start_stop = 1'b1;
      cycles(2);
      sw_if.btn_start_stop = 1'b0;
      cycles(10);
      expect_out("glitch_ignored", 16'h0000, 1'b0, 1'b0);

      // Long hold: exactly one press, RUN entered 6 edges after the raw rise.
      sw_if.btn_start_stop = 1'b1;
      cycles(5);
      expect_out("db_not_yet", 16'h0000, 1'b0, 1'b0);
      cycles(1);
      expect_out("db_running", 16'h0000, 1'b1, 1'b0);
      cycles(4);
      expect_out("first_tick", 16'h0001, 1'b1, 1'b0);
      sw_if.btn_start_stop = 1'b0;
      cycles(32);
      expect_out("count_9", 16'h0009, 1'b1, 1'b0);

      // Pause at 0010 with the prescaler part-way through a period.
      sw_if.btn_start_stop = 1'b1;
      cycles(4);
      expect_out("count_10", 16'h0010, 1'b1, 1'b0);
      cycles(2);
      expect_out("paused", 16'h0010, 1'b0, 1'b0);
      sw_if.btn_start_stop = 1'b0;
      cycles(100);
      expect_out("pause_hold", 16'h0010, 1'b0, 1'b0);

      // Resume: the held prescaler value 2 leaves two cycles to the next tick.
      sw_if.btn_start_stop = 1'b1;
      cycles(6);
      expect_out("resumed", 16'h0010, 1'b1, 1'b0);
      cycles(1);
      expect_out("resume_partial", 16'h0010, 1'b1, 1'b0);
      cycles(1);
      expect_out("resume_tick", 16'h0011, 1'b1, 1'b0);
      sw_if.btn_start_stop = 1'b0;

      // Press pulse on the same cycle as a tick: count 13->14 lands, then PAUSE.
      cycles(6);
      expect_out("pre_tick_press", 16'h0012, 1'b1, 1'b0);
      sw_if.btn_start_stop = 1'b1;
      cycles(6);
      expect_out("press_at_tick", 16'h0014, 1'b0, 1'b0);
      sw_if.btn_start_stop = 1'b0;
      cycles(8);
      expect_out("pause_after_tick", 16'h0014, 1'b0, 1'b0);

      press_clear();
      expect_out("clear", 16'h0000, 1'b0, 1'b0);
      cycles(8);

      // Count through the 0399->0400 double carry and on to 9999.
      press_start();
      expect_out("start2", 16'h0000, 1'b1, 1'b0);
      cycles(1596);
      expect_out("count_0399", 16'h0399, 1'b1, 1'b0);
      cycles(3);
      expect_out("carry_hold", 16'h0399, 1'b1, 1'b0);
      cycles(1);
      expect_out("carry_0400", 16'h0400, 1'b1, 1'b0);
      cycles(38396);
      expect_out("count_9999", 16'h9999, 1'b1, 1'b0);
      cycles(4);
`ifdef STOPWATCH_SATURATE_EN
      expect_out("sat_hold", 16'h9999, 1'b0, 1'b1);
      press_start();
      expect_out("sat_start_ignored", 16'h9999, 1'b0, 1'b1);
      cycles(8);
      expect_out("sat_still_paused", 16'h9999, 1'b0, 1'b1);
`else
      expect_out("wrap_0000", 16'h0000, 1'b1, 1'b1);
      cycles(4);
      expect_out("wrap_continue", 16'h0001, 1'b1, 1'b1);
`endif

      press_clear();
      expect_out("clear2", 16'h0000, 1'b0, 1'b0);
      cycles(8);

      // Clear and start_stop pulses in the same cycle while running at 0123.
      press_start();
      expect_out("start3", 16'h0000, 1'b1, 1'b0);
      cycles(488);
      expect_out("count_0122", 16'h0122, 1'b1, 1'b0);
      sw_if.btn_start_stop = 1'b1;
      sw_if.btn_clear      = 1'b1;
      cycles(4);
      expect_out("count_0123", 16'h0123, 1'b1, 1'b0);
      cycles(2);
      expect_out("sim_clear_wins", 16'h0000, 1'b0, 1'b0);
      sw_if.btn_start_stop = 1'b0;
      sw_if.btn_clear      = 1'b0;
      cycles(8);
      expect_out("idle_after_sim", 16'h0000, 1'b0, 1'b0);

      // ---------------- final report ----------------
      cycles(2);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL queue_drain: %0d expected entries left, want 0", exp_q.size());
      end
      checks++;
      if (nib_bad == 0) passed++;
      else $display("FAIL bcd_nibbles: %0d cycles showed a digit above 9, want 0", nib_bad);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Upstream feeder for the 4-digit seven-segment display stage. Conditions two raw push-buttons (synchronise, debounce, edge-detect) and runs a start/pause/clear state machine. Drives a 4-digit packed-BCD count, advanced by an internal prescaler, that the display stage scans onto the anodes and segments. All logic runs on the board clock with no derived clocks.

Parameters:
TICK_DIV, 100000, clk cycles per count increment; legal range >= 2.
DB_CYCLES, 50000, consecutive stable cycles required before a debounced button level changes; legal range >= 2.

Ports:
clk  input  1  board clock; all flops on rising edge.
rst  input  1  synchronous, active-high reset.
btn_start_stop  input  1  raw asynchronous button, active-high.
btn_clear  input  1  raw asynchronous button, active-high.
bcd_out  output  16  packed BCD count. [15:12] thousands (leftmost digit), [11:8] hundreds, [7:4] tens, [3:0] units.
running  output  1  high while the FSM is in RUN.
overflow  output  1  sticky flag; set when the count passes 9999.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high. On rst: FSM=IDLE, bcd_out=16'h0000, running=0, overflow=0, prescaler=0, sync/debounce flops=0, debounced levels=0. rst wins over every other event in the same cycle.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter: increments while the synced value differs from the debounced level; clears to 0 on any cycle where they match. When the counter reaches DB_CYCLES-1 while differing, the debounced level takes the synced value on that edge and the counter clears.
  - Rising edge of the debounced level gives a 1-cycle press pulse. Release is ignored.
  - Raw edge to press pulse: DB_CYCLES+2 cycles, ±1.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop pulse -> RUN.
  - RUN + start_stop pulse -> PAUSE.
  - PAUSE + start_stop pulse -> RUN.
  - Any state + clear pulse -> IDLE, with bcd_out=0, prescaler=0, overflow=0.
  - clear and start_stop pulses in the same cycle: clear wins; start_stop is dropped.
  - running is registered and equals (state==RUN).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. Holds its value in PAUSE, so a resumed run continues the partial period. Held at 0 in IDLE.
  - Issues a 1-cycle tick when it equals TICK_DIV-1 in RUN, then wraps to 0.
  - First tick after IDLE->RUN lands exactly TICK_DIV cycles after the RUN state is entered.
- BCD increment, on tick:
  - Units +1. A digit at 9 wraps to 0 and carries into the next digit in the same cycle.
  - bcd_out updates on the edge after the tick cycle; it is registered with no combinational path from the inputs.
  - Every nibble is always in 0..9.
  - 9999 + tick -> 0000 and overflow<=1 (default build). Count continues.
- A press while in RUN at the same cycle as a tick: the tick is applied, then the state moves to PAUSE.

Optional Feature:
Macro STOPWATCH_SATURATE_EN.
- Defined: a tick at 9999 leaves bcd_out=16'h9999, sets overflow=1 and forces FSM to PAUSE. start_stop from PAUSE while overflow=1 is ignored; only clear or rst exits.
- Undefined: wrap to 0000 with sticky overflow, as described in Behaviour.

Test Plan:
All scenarios use TICK_DIV=4, DB_CYCLES=3.
1. Reset: assert rst 2 cycles with buttons toggling -> bcd_out=0000, running=0, overflow=0 held throughout; first post-reset cycle identical.
2. Debounce: btn_start_stop glitch high 2 cycles then low -> no state change. Hold high 10 cycles -> running=1 within DB_CYCLES+2±1 cycles; exactly one press registered.
3. Counting: start, run 40 cycles -> bcd_out=0010; pause, wait 100 cycles -> unchanged at 0010; resume -> next tick arrives after the remaining prescaler cycles, not a full period.
4. Carry: preload via 399 ticks of run -> 0399; one more tick -> 0400 in one cycle. Nibbles never show A-F; checked every cycle.
5. Overflow: run to 9999, one more tick -> default 0000 with overflow=1 and still running. With STOPWATCH_SATURATE_EN -> holds 9999, running=0, start_stop ignored.
6. Simultaneous: clear and start_stop pulses in the same cycle while in RUN at 0123 -> IDLE, bcd_out=0000, overflow=0, running=0.
